// File: rtl/rf_wr_if.sv
// Register-file write-port bundle: WB and LU request channels plus the registered
// register-file write port and the address-mux select.
interface rf_wr_if #(
  parameter int DATA_W = 32
);
  // A channel transfers when valid && ready are both high in the same cycle.
  // ready never rises without valid. At most one ready is high in any cycle.
  // valid may drop without a transfer.
  logic              wb_valid;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;
  logic              lu_valid;
  logic [4:0]        lu_addr;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              mux_sel;
  logic              lu_starved;

  modport master (
    output wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
    input  wb_ready, lu_ready, rf_we, rf_waddr, rf_wdata, mux_sel, lu_starved
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
    output wb_ready, lu_ready, rf_we, rf_waddr, rf_wdata, mux_sel, lu_starved
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Two-requester register-file write-port arbiter (WB priority, $0 writes absorbed).
// Define RF_ARB_STARVE_EN to build the LU starvation counter and priority override.
module rf_wr_arbiter #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  rf_wr_if.slave     bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_WB = 2'd1,
    WR_LU = 2'd2
  } state_t;

  state_t state;
  logic   starve;
  logic   wb_xfer;
  logic   lu_xfer;

`ifdef RF_ARB_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] scnt;
  assign starve = !rst && bus.lu_valid && (scnt == LIMIT);
`else
  // STARVE_LIMIT has no effect in strict-priority builds.
  logic [3:0] starve_limit_unused;
  assign starve_limit_unused = 4'(STARVE_LIMIT);
  assign starve = 1'b0;
`endif

  assign bus.wb_ready   = !rst && bus.wb_valid && !starve;
  assign bus.lu_ready   = !rst && bus.lu_valid && (!bus.wb_valid || starve);
  assign bus.lu_starved = starve;

  assign wb_xfer = bus.wb_valid && bus.wb_ready;
  assign lu_xfer = bus.lu_valid && bus.lu_ready;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= 5'd0;
      bus.rf_wdata <= '0;
      bus.mux_sel  <= 1'b0;
`ifdef RF_ARB_STARVE_EN
      scnt         <= 4'd0;
`endif
    end else begin
      // A $0 transfer is still a grant; only the write enable is suppressed.
      if (wb_xfer) begin
        state        <= WR_WB;
        bus.rf_we    <= (bus.wb_addr != 5'd0);
        bus.rf_waddr <= bus.wb_addr;
        bus.rf_wdata <= bus.wb_data;
        bus.mux_sel  <= 1'b0;
      end else if (lu_xfer) begin
        state        <= WR_LU;
        bus.rf_we    <= (bus.lu_addr != 5'd0);
        bus.rf_waddr <= bus.lu_addr;
        bus.rf_wdata <= bus.lu_data;
        bus.mux_sel  <= 1'b1;
      end else begin
        state        <= IDLE;
        bus.rf_we    <= 1'b0;
      end
`ifdef RF_ARB_STARVE_EN
      if (!bus.lu_valid || lu_xfer) begin
        scnt <= 4'd0;
      end else if (scnt < LIMIT) begin
        scnt <= scnt + 4'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: reset, single writes, contention, starvation,
// $0 absorption and reset with a write in flight.
module tb_rf_wr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;
  int         total = 0;
  int         bad   = 0;

  rf_wr_if #(.DATA_W(32)) bus ();

  rf_wr_arbiter #(.DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    bus.wb_valid = wv;
    bus.wb_addr  = wa;
    bus.wb_data  = wd;
    bus.lu_valid = lv;
    bus.lu_addr  = la;
    bus.lu_data  = ld;
  endtask

  task automatic chk_ready(input string tag, input logic ew, input logic el, input logic es);
    chk({tag, "_wb_ready"}, 32'(bus.wb_ready), 32'(ew));
    chk({tag, "_lu_ready"}, 32'(bus.lu_ready), 32'(el));
    chk({tag, "_lu_starved"}, 32'(bus.lu_starved), 32'(es));
  endtask

  task automatic chk_port(input string tag, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic ms, input logic [1:0] st);
    chk({tag, "_rf_we"}, 32'(bus.rf_we), 32'(we));
    chk({tag, "_rf_waddr"}, 32'(bus.rf_waddr), 32'(wa));
    chk({tag, "_rf_wdata"}, bus.rf_wdata, wd);
    chk({tag, "_mux_sel"}, 32'(bus.mux_sel), 32'(ms));
    chk({tag, "_state"}, 32'(state_dbg), 32'(st));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic exp_lu;

    // Reset held for two cycles with both requesters active
    rst = 1'b1;
    drive(1'b1, 5'd5, 32'h5555_5555, 1'b1, 5'd6, 32'h6666_6666);
    tick();
    #1 chk_ready("rst1", 1'b0, 1'b0, 1'b0);
    tick();
    chk_ready("rst2", 1'b0, 1'b0, 1'b0);
    chk_port("rst", 1'b0, 5'd0, 32'h0, 1'b0, 2'd0);
    rst = 1'b0;

    // WB then LU, back to back
    drive(1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
    #1 chk_ready("wb_single", 1'b1, 1'b0, 1'b0);
    tick();
    chk_port("wb_single", 1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0, 2'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h1234_5678);
    #1 chk_ready("lu_single", 1'b0, 1'b1, 1'b0);
    tick();
    chk_port("lu_single", 1'b1, 5'd9, 32'h1234_5678, 1'b1, 2'd2);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk_port("idle_hold", 1'b0, 5'd9, 32'h1234_5678, 1'b1, 2'd0);

    // Contention: WB wins, LU follows once WB drops
    drive(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd4, 32'h0000_0044);
    #1 chk_ready("contend", 1'b1, 1'b0, 1'b0);
    tick();
    chk_port("contend_wb", 1'b1, 5'd3, 32'h0000_0033, 1'b0, 2'd1);
    bus.wb_valid = 1'b0;
    #1 chk_ready("contend_lu", 1'b0, 1'b1, 1'b0);
    tick();
    chk_port("contend_lu", 1'b1, 5'd4, 32'h0000_0044, 1'b1, 2'd2);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();

    // Continuous contention: override on the fifth cycle when enabled
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'd10, 32'h100 + 32'(i), 1'b1, 5'd11, 32'hAAAA_0000);
`ifdef RF_ARB_STARVE_EN
      exp_lu = (i == 4);
`else
      exp_lu = 1'b0;
`endif
      #1 chk_ready($sformatf("starve%0d", i), !exp_lu, exp_lu, exp_lu);
      tick();
      if (exp_lu) begin
        chk_port($sformatf("starve%0d", i), 1'b1, 5'd11, 32'hAAAA_0000, 1'b1, 2'd2);
      end else begin
        chk_port($sformatf("starve%0d", i), 1'b1, 5'd10, 32'h100 + 32'(i), 1'b0, 2'd1);
      end
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();

    // $0 write is granted but never enables the register file
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
    #1 chk_ready("zero", 1'b1, 1'b0, 1'b0);
    tick();
    chk_port("zero", 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 2'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();

    // Reset arriving right after a transfer drops any further write
    drive(1'b1, 5'd20, 32'h0000_A5A5, 1'b0, 5'd0, 32'h0);
    tick();
    chk_port("inflight_n1", 1'b1, 5'd20, 32'h0000_A5A5, 1'b0, 2'd1);
    rst = 1'b1;
    drive(1'b1, 5'd21, 32'h0000_5A5A, 1'b1, 5'd22, 32'h0000_0022);
    #1 chk_ready("inflight_rst", 1'b0, 1'b0, 1'b0);
    tick();
    chk_port("inflight_n2", 1'b0, 5'd0, 32'h0, 1'b0, 2'd0);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
